adder_checker: RTL and testbench

//  Stimulus/check engine under the host-facing test wrapper: drives pseudo-random operand pairs

---
 rtl/adder_checker.sv | 165 ++++++++++++++++
 tb/tb_adder_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_checker.sv
// adder_checker -- stimulus/check engine for an arithmetic DUT.
//
// Two 32-bit Fibonacci LFSRs (x^32+x^22+x^2+x+1) generate operand pairs.
// The engine computes the expected sum locally, checks the DUT result after
// DUT_LATENCY cycles, and keeps saturating sample and mismatch counters.
// A host-controlled freeze input holds the visible counter snapshot.
//
// Ports
//   clk          single clock, DUT included
//   reset        synchronous, active-high
//   enable       1 = issue a new operand pair every cycle (while in RUN)
//   freeze       1 = hold o_data_ctr / o_event_ctr; internal counting continues
//   o_drive_a/b  operands to the DUT (low WIDTH bits of the LFSRs)
//   i_dut_out    DUT sum
//   o_data_ctr   results checked (saturating, zero-extended to 32 bits)
//   o_event_ctr  mismatches detected (saturating, zero-extended to 32 bits)
//   o_debug      [1:0] FSM state (IDLE=0, RUN=1, DRAIN=2), [7:2] zero,
//                [31:8] first-error syndrome when FIRST_ERR_CAPTURE_EN is defined,
//                otherwise zero
//
// Build option: define FIRST_ERR_CAPTURE_EN to capture the low 24 bits of
// (i_dut_out ^ expected) on the first mismatch after reset (sticky).
module adder_checker #(
  parameter int          WIDTH       = 32,
  parameter int          DUT_LATENCY = 1,
  parameter int          CTR_WIDTH   = 32,
  parameter logic [31:0] SEED_A      = 32'h1,
  parameter logic [31:0] SEED_B      = 32'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             freeze,
  output logic [WIDTH-1:0] o_drive_a,
  output logic [WIDTH-1:0] o_drive_b,
  input  logic [WIDTH-1:0] i_dut_out,
  output logic [31:0]      o_data_ctr,
  output logic [31:0]      o_event_ctr,
  output logic [31:0]      o_debug
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [4:0] DRAIN_LAST = 5'(DUT_LATENCY - 1);

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [CTR_WIDTH-1:0] sat_inc(input logic [CTR_WIDTH-1:0] v);
    return (&v) ? v : v + CTR_WIDTH'(1);
  endfunction

  state_t                 state;
  logic [4:0]             drain_cnt;
  logic [31:0]            lfsr_a;
  logic [31:0]            lfsr_b;
  logic                   issue;
  logic                   vld_p0;
  logic [WIDTH-1:0]       sum_p0;
  logic                   vld_p1 [DUT_LATENCY];
  logic [WIDTH-1:0]       exp_p1 [DUT_LATENCY];
  logic                   head_vld;
  logic [WIDTH-1:0]       head_exp;
  logic                   mismatch;
  logic [CTR_WIDTH-1:0]   data_ctr;
  logic [CTR_WIDTH-1:0]   event_ctr;

  // The LFSR registers drive the DUT directly, so the operands are registered.
  assign o_drive_a = lfsr_a[WIDTH-1:0];
  assign o_drive_b = lfsr_b[WIDTH-1:0];
  assign issue     = (state == RUN) && enable;

  // Stage p0: vld_p0 marks that the pair currently on o_drive_* was issued;
  // its expected sum is taken from the same operands the DUT is seeing.
  assign sum_p0    = o_drive_a + o_drive_b;

  // Stage p1: DUT_LATENCY-deep pipe whose head lines up with i_dut_out.
  assign head_vld  = vld_p1[DUT_LATENCY-1];
  assign head_exp  = exp_p1[DUT_LATENCY-1];
  assign mismatch  = head_vld && (i_dut_out != head_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      lfsr_a      <= SEED_A;
      lfsr_b      <= SEED_B;
      vld_p0      <= 1'b0;
      for (int i = 0; i < DUT_LATENCY; i++) vld_p1[i] <= 1'b0;
      data_ctr    <= '0;
      event_ctr   <= '0;
      o_data_ctr  <= '0;
      o_event_ctr <= '0;
    end else begin
      case (state)
        IDLE: if (enable) state <= RUN;
        RUN: begin
          if (!enable) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          // Re-entering RUN keeps the pipe intact, so in-flight samples are still checked.
          if (enable)                       state     <= RUN;
          else if (drain_cnt == DRAIN_LAST) state     <= IDLE;
          else                              drain_cnt <= drain_cnt + 5'd1;
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        lfsr_a <= lfsr_step(lfsr_a);
        lfsr_b <= lfsr_step(lfsr_b);
      end

      vld_p0    <= issue;
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < DUT_LATENCY; i++) vld_p1[i] <= vld_p1[i-1];

      if (head_vld) data_ctr  <= sat_inc(data_ctr);
      if (mismatch) event_ctr <= sat_inc(event_ctr);

      // Snapshot registers: tracking when not frozen, holding while frozen.
      if (!freeze) begin
        o_data_ctr  <= 32'(data_ctr);
        o_event_ctr <= 32'(event_ctr);
      end
    end
  end

  // Expected-sum payload carries no control meaning, so it is left unreset.
  always_ff @(posedge clk) begin
    exp_p1[0] <= sum_p0;
    for (int i = 1; i < DUT_LATENCY; i++) exp_p1[i] <= exp_p1[i-1];
  end

`ifdef FIRST_ERR_CAPTURE_EN
  logic        first_seen;
  logic [23:0] syndrome;
  logic [31:0] diff32;

  assign diff32 = 32'(i_dut_out ^ head_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      first_seen <= 1'b0;
      syndrome   <= '0;
    end else if (mismatch && !first_seen) begin
      first_seen <= 1'b1;
      syndrome   <= diff32[23:0];
    end
  end

  assign o_debug = {syndrome, 6'b0, state};
`else
  assign o_debug = {24'b0, 6'b0, state};
`endif

endmodule

// File: tb/tb_adder_checker.sv
module tb_adder_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  // Main instance: WIDTH=32, DUT_LATENCY=1, CTR_WIDTH=32, registered adder with fault injection.
  logic        en_m = 1'b0, frz_m = 1'b0, inj_m = 1'b0;
  logic [31:0] a_m, b_m, dut_m, dc_m, ec_m, dbg_m;
  always_ff @(posedge clk) dut_m <= (a_m + b_m) ^ {31'b0, inj_m};

  adder_checker #(.WIDTH(32), .DUT_LATENCY(1), .CTR_WIDTH(32)) u_main (
    .clk(clk), .reset(reset), .enable(en_m), .freeze(frz_m),
    .o_drive_a(a_m), .o_drive_b(b_m), .i_dut_out(dut_m),
    .o_data_ctr(dc_m), .o_event_ctr(ec_m), .o_debug(dbg_m));

  // Saturation instance: WIDTH=16, CTR_WIDTH=4, every result faulty.
  logic        en_s = 1'b0;
  logic [15:0] a_s, b_s, dut_s;
  logic [31:0] dc_s, ec_s, dbg_s;
  always_ff @(posedge clk) dut_s <= (a_s + b_s) ^ 16'h0001;

  adder_checker #(.WIDTH(16), .DUT_LATENCY(1), .CTR_WIDTH(4)) u_sat (
    .clk(clk), .reset(reset), .enable(en_s), .freeze(1'b0),
    .o_drive_a(a_s), .o_drive_b(b_s), .i_dut_out(dut_s),
    .o_data_ctr(dc_s), .o_event_ctr(ec_s), .o_debug(dbg_s));

  // Latency-3 instance: WIDTH=8, three-stage registered adder.
  logic       en_l = 1'b0;
  logic [7:0] a_l, b_l, r0_l, r1_l, r2_l;
  logic [31:0] dc_l, ec_l, dbg_l;
  always_ff @(posedge clk) begin
    r0_l <= a_l + b_l;
    r1_l <= r0_l;
    r2_l <= r1_l;
  end

  adder_checker #(.WIDTH(8), .DUT_LATENCY(3), .CTR_WIDTH(32)) u_lat3 (
    .clk(clk), .reset(reset), .enable(en_l), .freeze(1'b0),
    .o_drive_a(a_l), .o_drive_b(b_l), .i_dut_out(r2_l),
    .o_data_ctr(dc_l), .o_event_ctr(ec_l), .o_debug(dbg_l));

  int checks = 0;
  int passed = 0;

  // Bench model of the operand generators plus the operand scoreboard.
  logic [31:0] ma, mb;
  logic [63:0] sb_q[$];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en_m = 1'b0; en_s = 1'b0; en_l = 1'b0; frz_m = 1'b0; inj_m = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    ma = 32'h1;
    mb = 32'hACE1;
    sb_q.delete();
  endtask

  // Issue n pairs on the main instance. Expected operands are pushed as each
  // pair is requested and popped when the DUT presents it. freeze_at >= 0 raises
  // freeze when the visible data counter reads that value and checks it holds.
  task automatic run_main(input int n, input bit faulty, input int freeze_at);
    logic [63:0] exp_pair;
    bit          froze;
    froze = 1'b0;
    en_m = 1'b1;
    cyc();
    for (int k = 0; k < n; k++) begin
      if (freeze_at >= 0 && !froze && dc_m == 32'(freeze_at)) begin
        frz_m = 1'b1;
        froze = 1'b1;
      end
      ma = lfsr_next(ma);
      mb = lfsr_next(mb);
      sb_q.push_back({ma, mb});
      cyc();
      exp_pair = sb_q.pop_front();
      checks++;
      if ({a_m, b_m} !== exp_pair)
        $display("FAIL operands k=%0d got %h_%h want %h", k, a_m, b_m, exp_pair);
      else passed++;
      if (froze) begin
        checks++;
        if (dc_m !== 32'(freeze_at)) $display("FAIL frozen_ctr k=%0d got %0d want %0d", k, dc_m, freeze_at);
        else passed++;
      end
      inj_m = faulty && (k % 4 == 3);
    end
    en_m = 1'b0;
    cyc();
    inj_m = 1'b0;
    if (freeze_at >= 0) begin
      checks++;
      if (froze !== 1'b1) $display("FAIL freeze_trigger got %0b want 1", froze);
      else passed++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dc_m !== 32'd0) $display("FAIL rst_data_ctr got %0d want 0", dc_m); else passed++;
    checks++; if (ec_m !== 32'd0) $display("FAIL rst_event_ctr got %0d want 0", ec_m); else passed++;
    checks++; if (dbg_m !== 32'd0) $display("FAIL rst_debug got %h want 0", dbg_m); else passed++;
    checks++; if (a_m !== 32'h1) $display("FAIL rst_drive_a got %h want 00000001", a_m); else passed++;
    checks++; if (b_m !== 32'hACE1) $display("FAIL rst_drive_b got %h want 0000ace1", b_m); else passed++;
    checks++; if ({a_s, b_s} !== 32'h0001ACE1) $display("FAIL rst_drive_w16 got %h_%h want 0001_ace1", a_s, b_s); else passed++;
    checks++; if ({a_l, b_l} !== 16'h01E1) $display("FAIL rst_drive_w8 got %h_%h want 01_e1", a_l, b_l); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    run_main(100, 1'b0, -1);
    repeat (5) cyc();
    checks++; if (dc_m !== 32'd100) $display("FAIL basic_data_ctr got %0d want 100", dc_m); else passed++;
    checks++; if (ec_m !== 32'd0) $display("FAIL basic_event_ctr got %0d want 0", ec_m); else passed++;
    checks++; if (dbg_m[1:0] !== 2'd0) $display("FAIL basic_state got %0d want 0", dbg_m[1:0]); else passed++;
    checks++; if ({a_m, b_m} !== {ma, mb}) $display("FAIL basic_hold got %h_%h want %h_%h", a_m, b_m, ma, mb); else passed++;
  endtask

  task automatic test_faults();
    logic [23:0] want_syn;
`ifdef FIRST_ERR_CAPTURE_EN
    want_syn = 24'h000001;
`else
    want_syn = 24'h000000;
`endif
    do_reset();
    run_main(100, 1'b1, -1);
    repeat (5) cyc();
    checks++; if (dc_m !== 32'd100) $display("FAIL fault_data_ctr got %0d want 100", dc_m); else passed++;
    checks++; if (ec_m !== 32'd25) $display("FAIL fault_event_ctr got %0d want 25", ec_m); else passed++;
    checks++; if (dbg_m[31:8] !== want_syn) $display("FAIL fault_syndrome got %h want %h", dbg_m[31:8], want_syn); else passed++;
  endtask

  task automatic test_freeze();
    do_reset();
    run_main(100, 1'b0, 40);
    repeat (4) cyc();
    checks++; if (dc_m !== 32'd40) $display("FAIL freeze_hold got %0d want 40", dc_m); else passed++;
    frz_m = 1'b0;
    cyc();
    checks++; if (dc_m !== 32'd100) $display("FAIL freeze_release got %0d want 100", dc_m); else passed++;
    checks++; if (ec_m !== 32'd0) $display("FAIL freeze_event_ctr got %0d want 0", ec_m); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    en_s = 1'b1;
    cyc();
    repeat (20) cyc();
    en_s = 1'b0;
    repeat (5) cyc();
    checks++; if (dc_s !== 32'd15) $display("FAIL sat_data_ctr got %0d want 15", dc_s); else passed++;
    checks++; if (ec_s !== 32'd15) $display("FAIL sat_event_ctr got %0d want 15", ec_s); else passed++;
  endtask

  task automatic test_drain_rerun();
    do_reset();
    en_l = 1'b1;
    cyc();
    repeat (10) cyc();
    en_l = 1'b0;
    cyc();
    checks++; if (dbg_l[1:0] !== 2'd2) $display("FAIL lat3_drain got %0d want 2", dbg_l[1:0]); else passed++;
    en_l = 1'b1;
    cyc();
    checks++; if (dbg_l[1:0] !== 2'd1) $display("FAIL lat3_rerun got %0d want 1", dbg_l[1:0]); else passed++;
    repeat (10) cyc();
    en_l = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++; if (dbg_l[1:0] !== 2'd2) $display("FAIL lat3_drain_len got %0d want 2", dbg_l[1:0]); else passed++;
    cyc();
    checks++; if (dbg_l[1:0] !== 2'd0) $display("FAIL lat3_idle got %0d want 0", dbg_l[1:0]); else passed++;
    repeat (3) cyc();
    checks++; if (dc_l !== 32'd20) $display("FAIL lat3_data_ctr got %0d want 20", dc_l); else passed++;
    checks++; if (ec_l !== 32'd0) $display("FAIL lat3_event_ctr got %0d want 0", ec_l); else passed++;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    en_m = 1'b1;
    repeat (12) cyc();
    frz_m = 1'b1;
    repeat (10) cyc();
    reset = 1'b1;
    cyc();
    checks++; if (dc_m !== 32'd0) $display("FAIL midrst_data_ctr got %0d want 0", dc_m); else passed++;
    checks++; if (ec_m !== 32'd0) $display("FAIL midrst_event_ctr got %0d want 0", ec_m); else passed++;
    checks++; if (a_m !== 32'h1) $display("FAIL midrst_drive_a got %h want 00000001", a_m); else passed++;
    checks++; if (dbg_m !== 32'd0) $display("FAIL midrst_debug got %h want 0", dbg_m); else passed++;
    reset = 1'b0;
    en_m = 1'b0;
    frz_m = 1'b0;
    repeat (4) cyc();
    checks++; if (dc_m !== 32'd0) $display("FAIL midrst_discard got %0d want 0", dc_m); else passed++;
  endtask

  initial begin
    ma = 32'h1;
    mb = 32'hACE1;
    test_reset();
    test_basic();
    test_faults();
    test_freeze();
    test_saturate();
    test_drain_rerun();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
